// File: rtl/maxnet_engine.sv
// maxnet_engine -- winner-take-all engine built on MaxNet lateral inhibition.
//
// A run loads N unsigned W-bit words. It then applies one inhibition step per
// clock, where every channel is reduced by eps times the sum of all the other
// channels. This repeats until a single non-zero channel survives, all
// channels reach zero, the state stops changing, or MAX_ITER steps are used
// up. The engine then reports the original input of the strongest channel
// and that channel's index.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   start_i, eps_i             begin a run (accepted in IDLE/DONE); Q0.F coefficient
//   in_valid_i, in_data_i      load words, channel order 0..N-1
//   in_ready_o                 high while loading
//   busy_o, done_o             loading/iterating; result valid (level)
//   max_o, winner_o            winning original value and channel index
//   iterations_o               update steps performed in this run
//   tie_o, timeout_o, none_o   termination reason flags

// One channel of the inhibition update: y' = max(y - (eps*(S-y))>>F, 0)
module maxnet_lane #(
  parameter int W  = 8,
  parameter int F  = 8,
  parameter int SW = 10
) (
  input  logic [W-1:0]  y_i,
  input  logic [SW-1:0] sum_i,
  input  logic [F-1:0]  eps_i,
  output logic [W-1:0]  y_o
);
  logic [SW-1:0]   rest;
  logic [SW+F-1:0] prod;
  logic [SW-1:0]   p;

  assign rest = sum_i - SW'(y_i);
  assign prod = (SW+F)'(rest) * (SW+F)'(eps_i);
  // eps < 1, so the shifted product always fits in SW bits
  assign p    = SW'(prod >> F);
  assign y_o  = (SW'(y_i) > p) ? (y_i - W'(p)) : '0;
endmodule

module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int F        = 8,
  parameter int MAX_ITER = 255,
  parameter int IW       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [F-1:0]         eps_i,
  input  logic                 in_valid_i,
  input  logic [W-1:0]         in_data_i,
  output logic                 in_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [W-1:0]         max_o,
  output logic [$clog2(N)-1:0] winner_o,
  output logic [IW-1:0]        iterations_o,
  output logic                 tie_o,
  output logic                 timeout_o,
  output logic                 none_o
);
  localparam int NW  = $clog2(N);
  localparam int SW  = W + NW;
  localparam int NZW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [NW-1:0]           idx_q, idx_d;
  logic [F-1:0]            eps_q, eps_d;
  logic [N-1:0][W-1:0]     x_q, x_d;
  logic [N-1:0][W-1:0]     y_q, y_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic                    changed_q, changed_d;
  logic [W-1:0]            max_q, max_d;
  logic [NW-1:0]           winner_q, winner_d;
  logic                    tie_q, tie_d;
  logic                    timeout_q, timeout_d;
  logic                    none_q, none_d;

  logic [SW-1:0]           sum;
  logic [NZW-1:0]          nz;
  logic [N-1:0][W-1:0]     y_nxt;
  logic [NW-1:0]           best_idx;
  logic [W-1:0]            best_val;
  logic                    term;

  // Sum of all channels, number of survivors and argmax of the current state
  always_comb begin
    sum      = '0;
    nz       = '0;
    best_idx = '0;
    best_val = y_q[0];
    for (int i = 0; i < N; i++) begin
      sum = sum + SW'(y_q[i]);
      if (y_q[i] != '0) nz = nz + NZW'(1);
    end
    // strict compare keeps the lowest index on equal values
    for (int i = 1; i < N; i++) begin
      if (y_q[i] > best_val) begin
        best_val = y_q[i];
        best_idx = NW'(i);
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    maxnet_lane #(.W(W), .F(F), .SW(SW)) u_lane (
      .y_i   (y_q[g]),
      .sum_i (sum),
      .eps_i (eps_q),
      .y_o   (y_nxt[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    eps_d     = eps_q;
    x_d       = x_q;
    y_d       = y_q;
    iter_d    = iter_q;
    changed_d = changed_q;
    max_d     = max_q;
    winner_d  = winner_q;
    tie_d     = tie_q;
    timeout_d = timeout_q;
    none_d    = none_q;
    term      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          iter_d    = '0;
          tie_d     = 1'b0;
          timeout_d = 1'b0;
          none_d    = 1'b0;
          eps_d     = eps_i;
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          x_d[idx_q] = in_data_i;
          y_d[idx_q] = in_data_i;
          if (idx_q == NW'(N - 1)) begin
            state_d   = S_ITER;
            // no update has happened yet, so a stall cannot be claimed
            changed_d = 1'b1;
          end else begin
            idx_d = idx_q + NW'(1);
          end
        end
      end
      S_ITER: begin
        term = 1'b1;
        if (nz == NZW'(1)) begin
          // single survivor, no flag
        end else if (nz == '0) begin
          none_d = 1'b1;
        end else if (!changed_q) begin
          tie_d = 1'b1;
        end else if (iter_q == IW'(MAX_ITER)) begin
          timeout_d = 1'b1;
        end else begin
          term = 1'b0;
        end
        if (term) begin
          state_d  = S_DONE;
          winner_d = (nz == '0) ? '0 : best_idx;
          max_d    = (nz == '0) ? '0 : x_q[best_idx];
        end else begin
          y_d       = y_nxt;
          iter_d    = iter_q + IW'(1);
          changed_d = (y_nxt != y_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      eps_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      iter_q    <= '0;
      changed_q <= 1'b0;
      max_q     <= '0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      eps_q     <= eps_d;
      x_q       <= x_d;
      y_q       <= y_d;
      iter_q    <= iter_d;
      changed_q <= changed_d;
      max_q     <= max_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
      none_q    <= none_d;
    end
  end

  assign in_ready_o   = (state_q == S_LOAD);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_ITER);
  assign done_o       = (state_q == S_DONE);
  assign max_o        = max_q;
  assign winner_o     = winner_q;
  assign iterations_o = iter_q;
  assign tie_o        = tie_q;
  assign timeout_o    = timeout_q;
  assign none_o       = none_q;
endmodule

// File: doc/maxnet_engine.md
# maxnet_engine

Parametrised winner-take-all engine that iterates MaxNet lateral inhibition over N unsigned W-bit inputs until a single survivor remains, then reports the largest input and its index. It generalises the fixed four-channel max-set datapath. It adds a configurable channel count and width, a run-time inhibition coefficient, a ready/valid load port, and detection of stalled ties and iteration timeouts. It sits between the input-vector source and any consumer of the winning value and index.

## Interface
- N, 4: channel count, ≥2.
- W, 8: input/state width, unsigned.
- F, 8: fraction bits of epsilon (Q0.F).
- MAX_ITER, 255: iteration limit, ≥1.
- IW, 8: iteration counter width; 2^IW > MAX_ITER.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- eps  in  F  inhibition coefficient, Q0.F; sampled on the start cycle.
- in_valid  in  1  load word valid.
- in_data  in  W  load word; channel order 0..N-1.
- in_ready  out  1  high in LOAD.
- busy  out  1  high in LOAD or ITER.
- done  out  1  level, high in DONE.
- max  out  W  original input of the winning channel.
- winner  out  clog2(N)  winning channel index.
- iterations  out  IW  update steps performed.
- tie  out  1  run ended by stall with more than one survivor.
- timeout  out  1  run ended by MAX_ITER.
- none  out  1  all state values reached zero.

## Operation
- States: IDLE → LOAD on start. LOAD → ITER after N accepted words. ITER → DONE on a termination condition. DONE → LOAD on start.
- Entering LOAD:
  - clears the load index, iteration count, and all flags.
  - drops done.
  - latches eps.
- LOAD behaviour:
  - each in_valid & in_ready cycle writes in_data to x[idx] and y[idx], then idx++.
  - the transfer at idx = N-1 moves the block to ITER.
- ITER evaluates the current y in each cycle, in this priority order:
  - nz = count of y_i ≠ 0. If nz == 1 → DONE.
  - if nz == 0 → DONE with none = 1.
  - if the previous update changed no y_i and nz > 1 → DONE with tie = 1.
  - if iterations == MAX_ITER → DONE with timeout = 1.
  - otherwise apply the update and increment iterations.
- Update rule, all channels in parallel:
  - S = Σ y_j, width W + clog2(N).
  - p_i = (eps × (S − y_i)) >> F, truncated.
  - y_i' = (y_i > p_i) ? y_i − p_i : 0.
- Result registered on the DONE transition:
  - winner = argmax of y; the lowest index wins on equal values.
  - max = x[winner].
  - with none = 1: winner = 0 and max = 0.
- Results and flags hold in DONE until the next start.
- start is ignored during LOAD and ITER. in_valid is ignored outside LOAD.
- eps = 0 gives no change, so the run ends by stall (tie) unless nz ≤ 1.

## Timing
- Reset values:
  - in_ready = 0, busy = 0, done = 0, max = 0, winner = 0.
  - iterations = 0, tie = 0, timeout = 0, none = 0.
  - state = IDLE.
- start in cycle t → in_ready = 1 at cycle t+1.
- The last load handshake at cycle t → ITER at t+1. done rises at t+2+iterations.
- One update per clock. Update and termination logic are a single combinational stage between the y registers.
- Reset asserted mid-run aborts immediately to IDLE. No partial result is kept.
- If start and reset coincide, reset wins.

## Test plan
- N=4, W=8, F=8, eps=0x20, inputs {10,20,30,40} → done with winner=3, max=40, iterations=8, all flags 0. Intermediate y after step 1 = {0,10,22,33}.
- Same inputs with MAX_ITER=4 → timeout=1, iterations=4, winner=3 (y = {0,0,10,26}), max=40.
- Inputs {50,50,0,0}, eps=0x20 → run ends by stall with tie=1, timeout=0, winner=0, max=50.
- Inputs {0,0,0,0} → done 2 cycles after the last load, none=1, iterations=0, max=0.
- Inputs {0,0,7,0} → immediate single survivor: iterations=0, winner=2, max=7.
- Throttled in_valid (every other cycle) plus a reset pulse mid-ITER → outputs return to the reset values, in_ready=0. A subsequent run with {10,20,30,40} reproduces the first scenario exactly.
